pipe_regfile: RTL and testbench
===============================

PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter DATA_W, 64, register data width in bits.
REQ-002 SHALL have parameter NREGS, 15, number of implemented registers (2..15).
REQ-003 SHALL have parameter ADDR_W, 4, register-id width.
REQ-004 SHALL have parameter RNONE, 15, register id meaning "no register".
REQ-005 SHALL have parameter INIT_MODE, 1, post-reset fill value: 0 = all zero, 1 = reg[i] = i.
REQ-006 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have port srcA  in  ADDR_W  decode read port A register id.
REQ-009 SHALL have port srcB  in  ADDR_W  decode read port B register id.
REQ-010 SHALL have port valA  out  DATA_W  read data, port A.
REQ-011 SHALL have port valB  out  DATA_W  read data, port B.
REQ-012 SHALL have port dstE  in  ADDR_W  write-back E destination id (RNONE = no write).
REQ-013 SHALL have port valE  in  DATA_W  write-back E data.
REQ-014 SHALL have port dstM  in  ADDR_W  write-back M destination id (RNONE = no write).
REQ-015 SHALL have port valM  in  DATA_W  write-back M data.
REQ-016 SHALL have port ready  out  1  high when init complete and ports are live.
REQ-017 SHALL have port dbg_addr  in  ADDR_W  debug read address.
REQ-018 SHALL have port dbg_data  out  DATA_W  debug read data (array contents, no bypass).

Function
REQ-019 SHALL implement two-state FSM INIT -> RUN; rst_n low forces INIT, init counter = 0, all registers = 0, ready = 0.
REQ-020 In INIT, SHALL write reg[cnt] = (INIT_MODE ? cnt : 0) each cycle, cnt incrementing 0..NREGS-1; counter SHALL NOT wrap.
REQ-021 SHALL move INIT -> RUN on the edge writing reg[NREGS-1]; ready SHALL be 1 from the next cycle; fill takes exactly NREGS cycles after rst_n deasserts.
REQ-022 RUN SHALL be terminal until rst_n asserts; reset mid-INIT SHALL restart fill from cnt = 0.
REQ-023 In INIT, dstE/dstM writes SHALL be ignored and valA/valB SHALL read 0.
REQ-024 A destination is valid iff id != RNONE and id < NREGS; invalid destinations SHALL cause no write.
REQ-025 In RUN, valid dstE SHALL write valE and valid dstM SHALL write valM on the rising edge (0-cycle write latency, visible in array next cycle).
REQ-026 If dstE == dstM and valid, SHALL write valM only (M priority, popq %rsp semantics).
REQ-027 valA/valB SHALL be combinational; srcX == RNONE or srcX >= NREGS SHALL return 0.
REQ-028 In RUN, read SHALL bypass same-cycle writes: srcX == valid dstM -> valM; else srcX == valid dstE -> valE; else reg[srcX].
REQ-029 Both read ports SHALL be independent; srcA == srcB SHALL return identical values.
REQ-030 dbg_data SHALL return reg[dbg_addr] combinationally, 0 for out-of-range ids, in both states, without bypass.
REQ-031 All arithmetic on ids SHALL be ADDR_W wide; data SHALL pass unmodified (no sign/zero extension).

Reset
REQ-032 On rst_n low, registers, counter and FSM SHALL clear immediately, independent of clk; ready = 0, valA = valB = 0.
REQ-033 After rst_n rises, first fill write SHALL occur on the first rising clk edge.

Verification
REQ-034 Reset release, INIT_MODE=1, NREGS=15 -> ready rises after 15 edges; dbg reads reg[i] = i for i = 0..14.
REQ-035 RUN, dstE=3 valE=0x55, srcA=3 same cycle -> valA=0x55 combinationally; next cycle dstE=RNONE, valA=0x55 from array.
REQ-036 RUN, dstE=dstM=4, valE=0x10, valM=0x20, srcB=4 -> valB=0x20; next cycle reg[4]=0x20.
REQ-037 RUN, dstE=RNONE, dstM=15, srcA=RNONE -> no register changes; valA=0.
REQ-038 rst_n low at cnt=6 then released -> all registers 0 during reset; fill restarts; ready after 15 further edges; writes during INIT ignored.
REQ-039 NREGS=8, DATA_W=32: srcA=9, dstE=9 -> valA=0, no write; reg[7] written and read correctly.

Source files
------------

// File: rtl/pipe_regfile.sv
// pipe_regfile: two-read, two-write pipeline register file with power-on fill,
// same-cycle write-to-read bypass (M over E) and a raw debug read port.
module pipe_regfile #(
  parameter int DATA_W    = 64,
  parameter int NREGS     = 15,
  parameter int ADDR_W    = 4,
  parameter int RNONE     = 15,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam logic [ADDR_W-1:0] NR = ADDR_W'(NREGS);
  localparam logic [ADDR_W-1:0] RN = ADDR_W'(RNONE);
  typedef enum logic {INIT, RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [NREGS];
  logic              run, we, wm;
  assign run = state == RUN;
  assign we  = run && dstE != RN && dstE < NR;
  assign wm  = run && dstM != RN && dstM < NR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (!run) begin
      regs[cnt] <= INIT_MODE != 0 ? DATA_W'(cnt) : '0;
      if (cnt == NR - 1'b1) begin
        state <= RUN;
        ready <= 1'b1;
      end else
        cnt <= cnt + 1'b1;
    end else begin
      // M is written last so it wins when both ports target the same register
      if (we) regs[dstE] <= valE;
      if (wm) regs[dstM] <= valM;
    end
  assign valA = (!run || srcA == RN || srcA >= NR) ? '0 :
                (wm && srcA == dstM) ? valM :
                (we && srcA == dstE) ? valE : regs[srcA];
  assign valB = (!run || srcB == RN || srcB >= NR) ? '0 :
                (wm && srcB == dstM) ? valM :
                (we && srcB == dstE) ? valE : regs[srcB];
  assign dbg_data = dbg_addr < NR ? regs[dbg_addr] : '0;
endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed plus randomized checks of two register-file configurations
// against an array model of the architectural register state.
module tb_pipe_regfile;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0]  srcA, srcB, dstE, dstM, dbg_addr;
  logic [63:0] valE, valM, valA, valB, dbg_data;
  logic        ready;
  logic [3:0]  s8A, s8B, d8E, d8M, dbg8;
  logic [31:0] v8E, v8M, va8, vb8, dbg8d;
  logic        rdy8;
  int checks = 0, errors = 0;
  logic [63:0] m [15];
  logic [31:0] m8 [8];

  pipe_regfile dut (.clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .ready(ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data));
  pipe_regfile #(.DATA_W(32), .NREGS(8)) dut8 (.clk(clk), .rst_n(rst_n), .srcA(s8A), .srcB(s8B),
    .valA(va8), .valB(vb8), .dstE(d8E), .valE(v8E), .dstM(d8M), .valM(v8M), .ready(rdy8),
    .dbg_addr(dbg8), .dbg_data(dbg8d));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [3:0] s, de, dm, input logic [63:0] ve, vm);
    if (s >= 15) return 64'd0;
    if (dm == s) return vm;
    if (de == s) return ve;
    return m[s];
  endfunction

  function automatic logic [31:0] rd8(input logic [3:0] s, de, dm, input logic [31:0] ve, vm);
    if (s >= 8) return 32'd0;
    if (dm == s) return vm;
    if (de == s) return ve;
    return m8[s];
  endfunction

  task automatic idle();
    srcA = 15; srcB = 15; dstE = 15; dstM = 15; dbg_addr = 0; valE = 0; valM = 0;
    s8A = 15; s8B = 15; d8E = 15; d8M = 15; dbg8 = 0; v8E = 0; v8M = 0;
  endtask

  task automatic step(input logic [3:0] a, b, de, dm, da, input logic [63:0] ve, vm);
    srcA = a; srcB = b; dstE = de; dstM = dm; dbg_addr = da; valE = ve; valM = vm;
    #2;
    chk("valA", valA, rd(a, de, dm, ve, vm));
    chk("valB", valB, rd(b, de, dm, ve, vm));
    chk("dbg", dbg_data, da < 15 ? m[da] : 64'd0);
    if (de < 15) m[de] = ve;
    if (dm < 15) m[dm] = vm;
    @(posedge clk); #1;
  endtask

  task automatic step8(input logic [3:0] a, b, de, dm, da, input logic [31:0] ve, vm);
    s8A = a; s8B = b; d8E = de; d8M = dm; dbg8 = da; v8E = ve; v8M = vm;
    #2;
    chk("valA8", va8, rd8(a, de, dm, ve, vm));
    chk("valB8", vb8, rd8(b, de, dm, ve, vm));
    chk("dbg8", dbg8d, da < 8 ? m8[da] : 32'd0);
    if (de < 8) m8[de] = ve;
    if (dm < 8) m8[dm] = vm;
    @(posedge clk); #1;
  endtask

  // Releases reset and walks the fill, pushing writes that must be ignored.
  task automatic do_init();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      srcA = 4'(i); dstE = 4'(i); dstM = 4'((i + 1) % 15); valE = 64'hdead; valM = 64'hbeef;
      #1;
      chk("ready_init", ready, 1'b0);
      chk("valA_init", valA, 64'd0);
      chk("ready8", rdy8, i >= 8);
      @(posedge clk); #1;
    end
    idle();
    #1;
    chk("ready_run", ready, 1'b1);
    for (int i = 0; i < 15; i++) begin
      m[i] = 64'(i);
      dbg_addr = 4'(i); #1;
      chk("dbg_fill", dbg_data, 64'(i));
    end
    for (int i = 0; i < 8; i++) begin
      m8[i] = 32'(i);
      dbg8 = 4'(i); #1;
      chk("dbg8_fill", dbg8d, 64'(i));
    end
    dbg_addr = 0; dbg8 = 0;
  endtask

  initial begin
    idle();
    #12;
    chk("rst_ready", ready, 1'b0);
    chk("rst_valA", valA, 64'd0);
    chk("rst_dbg", dbg_data, 64'd0);
    do_init();
    @(posedge clk); #1;
    srcA = 3; dstE = 3; valE = 64'h55; #1;
    chk("bypassE", valA, 64'h55);
    step(3, 15, 3, 15, 3, 64'h55, 64'd0);
    step(3, 3, 15, 15, 3, 64'd0, 64'd0);
    chk("arrayE", valA, 64'h55);
    srcB = 4; dstE = 4; dstM = 4; valE = 64'h10; valM = 64'h20; #1;
    chk("bypassM_prio", valB, 64'h20);
    step(15, 4, 4, 4, 4, 64'h10, 64'h20);
    dbg_addr = 4; #1;
    chk("arrayM_prio", dbg_data, 64'h20);
    step(15, 15, 15, 15, 15, 64'h1, 64'h2);
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i); #1;
      chk("no_change", dbg_data, m[i]);
    end
    for (int n = 0; n < 300; n++)
      step(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
           4'($urandom_range(15)), 4'($urandom_range(15)), {$urandom, $urandom}, {$urandom, $urandom});
    step8(9, 7, 9, 15, 9, 32'h1234, 32'd0);
    step8(9, 7, 7, 15, 9, 32'hcafe_f00d, 32'd0);
    step8(7, 7, 15, 15, 7, 32'd0, 32'd0);
    chk("reg7", va8, 32'hcafe_f00d);
    for (int n = 0; n < 150; n++)
      step8(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
            4'($urandom_range(15)), 4'($urandom_range(15)), $urandom, $urandom);
    idle();
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("async_ready", ready, 1'b0);
    chk("async_ready8", rdy8, 1'b0);
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i); #1;
      chk("async_clear", dbg_data, 64'd0);
    end
    dbg_addr = 3;
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("partial_fill", dbg_data, 64'd3);
    #2 rst_n = 1'b0; #1;
    chk("midinit_clear", dbg_data, 64'd0);
    #10;
    do_init();
    for (int n = 0; n < 40; n++)
      step(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
           4'($urandom_range(15)), 4'($urandom_range(15)), {$urandom, $urandom}, {$urandom, $urandom});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
